// File: rtl/sdmac_pkg.sv
// rtl/sdmac_pkg.sv - shared constants for the SDMAC register file
// Purpose: register offsets (ADDR = CPU A[6:2]), CNTR and ISTR bit positions,
//          _DSACK encodings and the ISTR assembly helper.
// Ports:   none (package)
package sdmac_pkg;

   localparam int ADDR_W = 5;

   // Register select values on ADDR (byte offset = value * 4)
   localparam logic [ADDR_W-1:0] REG_DAWR    = 5'd0;
   localparam logic [ADDR_W-1:0] REG_WTC     = 5'd1;
   localparam logic [ADDR_W-1:0] REG_CNTR    = 5'd2;
   localparam logic [ADDR_W-1:0] REG_ACR     = 5'd3;
   localparam logic [ADDR_W-1:0] REG_ST_DMA  = 5'd4;
   localparam logic [ADDR_W-1:0] REG_FLUSH   = 5'd5;
   localparam logic [ADDR_W-1:0] REG_CLR_INT = 5'd6;
   localparam logic [ADDR_W-1:0] REG_ISTR    = 5'd7;
   localparam logic [ADDR_W-1:0] REG_SP_DMA  = 5'd15;

   // CNTR bit positions
   localparam int CNTR_DDIR   = 1;
   localparam int CNTR_INTENA = 2;
   localparam int CNTR_PRESET = 4;

   // ISTR bit positions
   localparam int ISTR_FE    = 0;
   localparam int ISTR_FF    = 1;
   localparam int ISTR_INT_P = 4;
   localparam int ISTR_INTS  = 5;
   localparam int ISTR_E_INT = 6;
   localparam int ISTR_INT_F = 8;

   // _DSACK encodings (active low)
   localparam logic [1:0] DSACK_32   = 2'b00;
   localparam logic [1:0] DSACK_IDLE = 2'b11;

   function automatic logic [31:0] istr_value(
      input logic fifo_empty,
      input logic fifo_full,
      input logic inta,
      input logic intena,
      input logic e_int
   );
      logic [31:0] v;
      v             = '0;
      v[ISTR_FE]    = fifo_empty;
      v[ISTR_FF]    = fifo_full;
      v[ISTR_INT_P] = inta & intena;
      v[ISTR_INTS]  = inta;
      v[ISTR_E_INT] = e_int;
      v[ISTR_INT_F] = inta | e_int;
      return v;
   endfunction

endpackage

// File: rtl/sdmac_bus_ack.sv
// rtl/sdmac_bus_ack.sv - 68030 bus cycle detection and _DSACK timing
// Purpose: qualifies CPU bus cycles, flags the first valid cycle of each
//          access exactly once and drives the 32-bit port acknowledge.
// Ports:   clk, rst        - clock, synchronous active-high reset
//          cs_n, as_n, ds_n - chip select / address strobe / data strobe (low)
//          r_w             - 1 = read, 0 = write
//          rd_valid        - read cycle currently valid (drives DOUT capture)
//          start           - first valid cycle of the access (one per cycle)
//          dsack           - _DSACK output encoding
module sdmac_bus_ack
   import sdmac_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       cs_n,
   input  logic       as_n,
   input  logic       ds_n,
   input  logic       r_w,
   output logic       rd_valid,
   output logic       start,
   output logic [1:0] dsack
);

   logic acc;
   logic rd;
   logic wr;
   logic done;     // access already serviced in this bus cycle
   logic blocked;  // reset landed inside a bus cycle; ignore it until _AS rises
   logic ack_q;

   assign acc      = !cs_n && !as_n;
   assign rd       = acc && r_w;
   assign wr       = acc && !r_w && !ds_n;
   assign start    = (rd || wr) && !done && !blocked;
   assign rd_valid = rd && !blocked;
   assign dsack    = ack_q ? DSACK_32 : DSACK_IDLE;

   always_ff @(posedge clk) begin
      if (rst) begin
         done    <= 1'b0;
         // Only hold off if the reset interrupted a cycle still in flight.
         blocked <= !as_n;
         ack_q   <= 1'b0;
      end else begin
         if (as_n) begin
            done    <= 1'b0;
            blocked <= 1'b0;
         end else if (start) begin
            done    <= 1'b1;
         end

         if (as_n || cs_n)
            ack_q <= 1'b0;
         else if (start)
            ack_q <= 1'b1;
      end
   end

endmodule

// File: rtl/sdmac_registers.sv
// rtl/sdmac_registers.sv - SDMAC CPU-visible register file
// Purpose: holds DAWR/WTC/CNTR/ACR, assembles ISTR, raises one-cycle DMA
//          command strobes and the host interrupt, and answers CPU reads.
// Ports:   CLK, RST              - clock, synchronous active-high reset
//          ADDR, _CS, _AS, _DS, R_W, DIN - CPU bus cycle inputs
//          DOUT, _DSACK          - CPU read data and 32-bit port acknowledge
//          INTA, FIFOFULL, FIFOEMPTY - status inputs from SCSI chip / FIFO
//          WTC, ACR, CNTR        - register contents to the DMA engine
//          ST_DMA, SP_DMA, FLUSH - one-cycle command pulses
//          INT                   - registered host interrupt
module sdmac_registers
   import sdmac_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic [4:0]  ADDR,
   input  logic        _CS,
   input  logic        _AS,
   input  logic        _DS,
   input  logic        R_W,
   input  logic [31:0] DIN,
   output logic [31:0] DOUT,
   output logic [1:0]  _DSACK,
   input  logic        INTA,
   input  logic        FIFOFULL,
   input  logic        FIFOEMPTY,
   output logic [31:0] WTC,
   output logic [31:0] ACR,
   output logic [8:0]  CNTR,
   output logic        ST_DMA,
   output logic        SP_DMA,
   output logic        FLUSH,
   output logic        INT
);

   logic        rd_valid;
   logic        start;
   logic        wr_start;
   logic [1:0]  dawr;
   logic [31:0] wtc;
   logic [31:0] acr;
   logic [8:0]  cntr;
   logic        e_int;
   logic        int_q;
   logic        st_q;
   logic        sp_q;
   logic        fl_q;
   logic [31:0] dout_q;
   logic [31:0] rd_mux;

   sdmac_bus_ack u_bus_ack (
      .clk      (CLK),
      .rst      (RST),
      .cs_n     (_CS),
      .as_n     (_AS),
      .ds_n     (_DS),
      .r_w      (R_W),
      .rd_valid (rd_valid),
      .start    (start),
      .dsack    (_DSACK)
   );

   assign wr_start = start && !R_W;

   always_comb begin
      rd_mux = '0;
      case (ADDR)
         REG_DAWR: rd_mux = {30'b0, dawr};
         REG_WTC:  rd_mux = wtc;
         REG_CNTR: rd_mux = {23'b0, cntr};
         REG_ACR:  rd_mux = acr;
         REG_ISTR: rd_mux = istr_value(FIFOEMPTY, FIFOFULL, INTA,
                                       cntr[CNTR_INTENA], e_int);
         default:  rd_mux = '0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         dawr   <= '0;
         wtc    <= '0;
         cntr   <= '0;
         acr    <= '0;
         e_int  <= 1'b0;
         int_q  <= 1'b0;
         st_q   <= 1'b0;
         sp_q   <= 1'b0;
         fl_q   <= 1'b0;
         dout_q <= '0;
      end else begin
         if (wr_start) begin
            case (ADDR)
               REG_DAWR: dawr <= DIN[1:0];
               REG_WTC:  wtc  <= DIN;
               REG_CNTR: cntr <= DIN[8:0];
               REG_ACR:  acr  <= {DIN[31:2], 2'b00};  // longword aligned
               default:  ;
            endcase
         end

         // Strobe registers fire on reads and writes alike.
         st_q <= start && (ADDR == REG_ST_DMA);
         fl_q <= start && (ADDR == REG_FLUSH);
         sp_q <= start && (ADDR == REG_SP_DMA);

         // Clear has priority over set.
         if (start && (ADDR == REG_CLR_INT))
            e_int <= 1'b0;
         else if (start && (ADDR == REG_SP_DMA))
            e_int <= 1'b1;

         int_q  <= (INTA || e_int) && cntr[CNTR_INTENA];
         dout_q <= rd_valid ? rd_mux : 32'h0;
      end
   end

   assign DOUT   = dout_q;
   assign WTC    = wtc;
   assign ACR    = acr;
   assign CNTR   = cntr;
   assign ST_DMA = st_q;
   assign SP_DMA = sp_q;
   assign FLUSH  = fl_q;
   assign INT    = int_q;

endmodule

// File: tb/tb_sdmac_registers.sv
// tb/tb_sdmac_registers.sv - self-checking bench for sdmac_registers
module tb_sdmac_registers;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  addr;
   logic        cs_n, as_n, ds_n, r_w;
   logic [31:0] din;
   logic [31:0] dout;
   logic [1:0]  dsack;
   logic        inta, ffull, fempty;
   logic [31:0] wtc, acr;
   logic [8:0]  cntr;
   logic        st, sp, fl, intr;

   int checks = 0;
   int errors = 0;

   // Reference state
   logic [1:0]  m_dawr;
   logic [31:0] m_wtc, m_acr;
   logic [8:0]  m_cntr;
   logic        m_eint;

   sdmac_registers dut (
      .CLK(clk), .RST(rst), .ADDR(addr), ._CS(cs_n), ._AS(as_n), ._DS(ds_n),
      .R_W(r_w), .DIN(din), .DOUT(dout), ._DSACK(dsack), .INTA(inta),
      .FIFOFULL(ffull), .FIFOEMPTY(fempty), .WTC(wtc), .ACR(acr), .CNTR(cntr),
      .ST_DMA(st), .SP_DMA(sp), .FLUSH(fl), .INT(intr)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1);
   end

   function automatic logic [31:0] model_read(input logic [4:0] a);
      logic ie;
      ie = m_cntr[2];
      case (a)
         5'd0:    return {30'b0, m_dawr};
         5'd1:    return m_wtc;
         5'd2:    return {23'b0, m_cntr};
         5'd3:    return m_acr;
         5'd7:    return {23'b0, inta | m_eint, 1'b0, m_eint, inta, inta & ie,
                          2'b00, ffull, fempty};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_apply(input logic [4:0] a, input logic wr, input logic [31:0] d);
      if (wr) begin
         if (a == 5'd0) m_dawr = d[1:0];
         if (a == 5'd1) m_wtc  = d;
         if (a == 5'd2) m_cntr = d[8:0];
         if (a == 5'd3) m_acr  = d & 32'hFFFF_FFFC;
      end
      if (a == 5'd6)       m_eint = 1'b0;
      else if (a == 5'd15) m_eint = 1'b1;
   endtask

   task automatic model_reset();
      m_dawr = '0; m_wtc = '0; m_acr = '0; m_cntr = '0; m_eint = 1'b0;
   endtask

   function automatic logic [2:0] exp_strobes(input logic [4:0] a);
      return {a == 5'd4, a == 5'd5, a == 5'd15};
   endfunction

   // One complete bus cycle held for two clocks; returns observations only.
   task automatic bus_access(input logic [4:0] a, input logic wr, input logic [31:0] d,
                             output logic [1:0] ack1, output logic [1:0] ack2,
                             output logic [1:0] ack3, output logic [31:0] rdata,
                             output logic [2:0] s1, output logic [2:0] s2);
      @(negedge clk);
      addr = a; r_w = !wr; din = d; cs_n = 1'b0; as_n = 1'b0; ds_n = 1'b0;
      @(negedge clk);
      ack1 = dsack; rdata = dout; s1 = {st, fl, sp};
      @(negedge clk);
      ack2 = dsack; s2 = {st, fl, sp};
      cs_n = 1'b1; as_n = 1'b1; ds_n = 1'b1;
      addr = 5'($urandom_range(0, 31)); din = $urandom; r_w = 1'($urandom_range(0, 1));
      @(negedge clk);
      ack3 = dsack;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (wtc !== 32'h0) begin errors++; $display("FAIL reset_wtc: got %h expected 0", wtc); end
      checks++; if (acr !== 32'h0) begin errors++; $display("FAIL reset_acr: got %h expected 0", acr); end
      checks++; if (cntr !== 9'h0) begin errors++; $display("FAIL reset_cntr: got %h expected 0", cntr); end
      checks++; if (dsack !== 2'b11) begin errors++; $display("FAIL reset_dsack: got %b expected 11", dsack); end
      checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0", dout); end
      checks++; if ({st, fl, sp, intr} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {st, fl, sp, intr}); end
   endtask

   task automatic test_directed_rw();
      logic [1:0] a1, a2, a3; logic [31:0] rd; logic [2:0] s1, s2;
      bus_access(5'd1, 1'b1, 32'h00AAAAAA, a1, a2, a3, rd, s1, s2);
      model_apply(5'd1, 1'b1, 32'h00AAAAAA);
      checks++; if ({a1, a2, a3} !== 6'b000011) begin errors++; $display("FAIL wtc_write_ack: got %b expected 000011", {a1, a2, a3}); end
      checks++; if (wtc !== 32'h00AAAAAA) begin errors++; $display("FAIL wtc_write: got %h expected 00aaaaaa", wtc); end
      bus_access(5'd1, 1'b0, 32'h0, a1, a2, a3, rd, s1, s2);
      checks++; if (rd !== 32'h00AAAAAA || a1 !== 2'b00) begin errors++; $display("FAIL wtc_read: got %h/%b expected 00aaaaaa/00", rd, a1); end
      bus_access(5'd3, 1'b1, 32'hFFFFFFFF, a1, a2, a3, rd, s1, s2);
      model_apply(5'd3, 1'b1, 32'hFFFFFFFF);
      bus_access(5'd3, 1'b0, 32'h0, a1, a2, a3, rd, s1, s2);
      checks++; if (rd !== 32'hFFFFFFFC) begin errors++; $display("FAIL acr_align: got %h expected fffffffc", rd); end
      checks++; if (dout !== 32'h0) begin errors++; $display("FAIL dout_idle: got %h expected 0", dout); end
   endtask

   task automatic test_interrupt();
      logic [1:0] a1, a2, a3; logic [31:0] rd; logic [2:0] s1, s2;
      fempty = 1'b0; ffull = 1'b0;
      bus_access(5'd2, 1'b1, 32'h004, a1, a2, a3, rd, s1, s2);
      model_apply(5'd2, 1'b1, 32'h004);
      inta = 1'b1;
      bus_access(5'd7, 1'b0, 32'h0, a1, a2, a3, rd, s1, s2);
      checks++; if (rd !== 32'h130) begin errors++; $display("FAIL istr_inta: got %h expected 00000130", rd); end
      checks++; if (intr !== 1'b1) begin errors++; $display("FAIL int_set: got %b expected 1", intr); end
      inta = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (intr !== 1'b0) begin errors++; $display("FAIL int_clear: got %b expected 0", intr); end
   endtask

   task automatic test_sp_dma_eint();
      logic [1:0] a1, a2, a3; logic [31:0] rd; logic [2:0] s1, s2;
      bus_access(5'd15, 1'b0, 32'h0, a1, a2, a3, rd, s1, s2);
      model_apply(5'd15, 1'b0, 32'h0);
      checks++; if ({s1, s2} !== 6'b001000) begin errors++; $display("FAIL sp_dma_pulse: got %b expected 001000", {s1, s2}); end
      bus_access(5'd7, 1'b0, 32'h0, a1, a2, a3, rd, s1, s2);
      checks++; if (rd !== model_read(5'd7) || rd[6] !== 1'b1) begin errors++; $display("FAIL istr_eint_set: got %h expected %h", rd, model_read(5'd7)); end
      checks++; if (intr !== 1'b1) begin errors++; $display("FAIL int_from_eint: got %b expected 1", intr); end
      bus_access(5'd6, 1'b1, $urandom, a1, a2, a3, rd, s1, s2);
      model_apply(5'd6, 1'b1, 32'h0);
      bus_access(5'd7, 1'b0, 32'h0, a1, a2, a3, rd, s1, s2);
      checks++; if (rd[6] !== 1'b0) begin errors++; $display("FAIL istr_eint_clear: got %b expected 0", rd[6]); end
      checks++; if (intr !== 1'b0) begin errors++; $display("FAIL int_after_clr: got %b expected 0", intr); end
   endtask

   task automatic test_cs_high();
      @(negedge clk);
      addr = 5'd1; r_w = 1'b0; din = 32'h12345678; cs_n = 1'b1; as_n = 1'b0; ds_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (dsack !== 2'b11 || wtc !== m_wtc) begin errors++; $display("FAIL cs_high: got %b/%h expected 11/%h", dsack, wtc, m_wtc); end
      end
      as_n = 1'b1; ds_n = 1'b1;
   endtask

   task automatic test_unmapped();
      logic [1:0] a1, a2, a3; logic [31:0] rd; logic [2:0] s1, s2;
      bus_access(5'd9, 1'b0, 32'h0, a1, a2, a3, rd, s1, s2);
      checks++; if (rd !== 32'h0 || a1 !== 2'b00) begin errors++; $display("FAIL unmapped_read: got %h/%b expected 0/00", rd, a1); end
   endtask

   task automatic test_reset_midcycle();
      logic [1:0] a1, a2, a3; logic [31:0] rd; logic [2:0] s1, s2;
      @(negedge clk);
      addr = 5'd1; r_w = 1'b0; din = 32'hCAFEF00D; cs_n = 1'b0; as_n = 1'b0; ds_n = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      din = 32'h5555AAAA;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (dsack !== 2'b11 || wtc !== 32'h0) begin errors++; $display("FAIL reset_abort: got %b/%h expected 11/0", dsack, wtc); end
      end
      cs_n = 1'b1; as_n = 1'b1; ds_n = 1'b1;
      bus_access(5'd1, 1'b1, 32'h0BADBEEF, a1, a2, a3, rd, s1, s2);
      model_apply(5'd1, 1'b1, 32'h0BADBEEF);
      checks++; if (a1 !== 2'b00 || wtc !== m_wtc) begin errors++; $display("FAIL after_abort: got %b/%h expected 00/%h", a1, wtc, m_wtc); end
   endtask

   task automatic test_random();
      logic [1:0] a1, a2, a3; logic [31:0] rd, d, exp; logic [2:0] s1, s2;
      logic [4:0] a; logic wr;
      logic [4:0] mapped [9];
      mapped = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd15};
      for (int n = 0; n < 60; n++) begin
         a  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : mapped[$urandom_range(0, 8)];
         wr = 1'($urandom_range(0, 1));
         d  = $urandom;
         inta = 1'($urandom_range(0, 1)); ffull = 1'($urandom_range(0, 1)); fempty = 1'($urandom_range(0, 1));
         exp = wr ? 32'h0 : model_read(a);
         bus_access(a, wr, d, a1, a2, a3, rd, s1, s2);
         model_apply(a, wr, d);
         checks++; if ({a1, a2, a3} !== 6'b000011) begin errors++; $display("FAIL rnd_ack a=%0d: got %b expected 000011", a, {a1, a2, a3}); end
         checks++; if (rd !== exp) begin errors++; $display("FAIL rnd_dout a=%0d wr=%0b: got %h expected %h", a, wr, rd, exp); end
         checks++; if (s1 !== exp_strobes(a) || s2 !== 3'b0) begin errors++; $display("FAIL rnd_strobe a=%0d: got %b/%b expected %b/000", a, s1, s2, exp_strobes(a)); end
         checks++; if (wtc !== m_wtc || acr !== m_acr || cntr !== m_cntr) begin errors++; $display("FAIL rnd_regs: got %h %h %h expected %h %h %h", wtc, acr, cntr, m_wtc, m_acr, m_cntr); end
         checks++; if (intr !== ((inta | m_eint) & m_cntr[2])) begin errors++; $display("FAIL rnd_int: got %b expected %b", intr, (inta | m_eint) & m_cntr[2]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] a1, a2, a3; logic [31:0] rd, d; logic [2:0] s1, s2;
      logic [4:0] a;
      for (int n = 0; n < 8; n++) begin
         a = 5'($urandom_range(0, 3));
         d = $urandom;
         bus_access(a, 1'b1, d, a1, a2, a3, rd, s1, s2);
         model_apply(a, 1'b1, d);
         bus_access(a, 1'b0, 32'h0, a1, a2, a3, rd, s1, s2);
         checks++; if (rd !== model_read(a) || a1 !== 2'b00) begin errors++; $display("FAIL b2b a=%0d: got %h/%b expected %h/00", a, rd, a1, model_read(a)); end
      end
   endtask

   initial begin
      rst = 1'b0; addr = '0; cs_n = 1'b1; as_n = 1'b1; ds_n = 1'b1; r_w = 1'b1;
      din = '0; inta = 1'b0; ffull = 1'b0; fempty = 1'b0;
      model_reset();
      test_reset();
      test_directed_rw();
      test_interrupt();
      test_sp_dma_eint();
      test_cs_high();
      test_unmapped();
      test_reset_midcycle();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
